// File: rtl/rr_mux_arb.sv
// Registered N-channel mux with fixed-select or round-robin arbitration and a one-entry valid/ready output stage.
// Optional macro RR_MUX_ERR_CNT_EN adds an 8-bit saturating out-of-range-select counter (err_cnt).
module rr_mux_arb #(
  parameter int N = 3,
  parameter int W = 2,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SW-1:0]   s,
  input  logic [N*W-1:0]  a,
  input  logic [N-1:0]    a_valid,
  output logic [N-1:0]    a_ready,
  output logic [W-1:0]    y,
  output logic [SW-1:0]   y_chan,
  output logic            y_valid,
`ifdef RR_MUX_ERR_CNT_EN
  input  logic            y_ready,
  output logic [7:0]      err_cnt
`else
  input  logic            y_ready
`endif
);

  localparam logic [SW:0] N_LIM = (SW+1)'(N);

  logic [W-1:0]  chan_data [N];
  logic [W-1:0]  y_reg;
  logic [SW-1:0] y_chan_reg;
  logic          y_valid_reg;
  logic [SW-1:0] ptr_reg;

  logic          s_in_range;
  logic          can_load;
  logic          grant_valid;
  logic [SW-1:0] grant_idx;
  logic          xfer;
  logic          rr_found;
  logic [SW-1:0] rr_idx;
  logic [SW:0]   cand;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign chan_data[gi] = a[gi*W +: W];
    end
  endgenerate

  // Search ptr+1 .. ptr+N with wrap; ptr itself is the last candidate.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int i = 1; i <= N; i++) begin
      cand = {1'b0, ptr_reg} + (SW+1)'(i);
      if (cand >= N_LIM) cand = cand - N_LIM;
      if (!rr_found && a_valid[cand[SW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[SW-1:0];
      end
    end
  end

  assign s_in_range = ({1'b0, s} < N_LIM);

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (mode) begin
      grant_valid = rr_found;
      grant_idx   = rr_idx;
    end else begin
      grant_valid = s_in_range && a_valid[s];
      grant_idx   = s;
    end
  end

  assign can_load = !y_valid_reg || y_ready;
  assign xfer     = !rst && can_load && grant_valid;

  always_comb begin
    a_ready = '0;
    if (xfer) a_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_reg       <= '0;
      y_chan_reg  <= '0;
      y_valid_reg <= 1'b0;
      ptr_reg     <= SW'(N-1);
    end else if (xfer) begin
      y_reg       <= chan_data[grant_idx];
      y_chan_reg  <= grant_idx;
      y_valid_reg <= 1'b1;
      ptr_reg     <= grant_idx;
    end else if (y_ready) begin
      y_valid_reg <= 1'b0;
    end
  end

  assign y       = y_reg;
  assign y_chan  = y_chan_reg;
  assign y_valid = y_valid_reg;

`ifdef RR_MUX_ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_reg <= '0;
    end else if (!mode && !s_in_range && (|a_valid) && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_rr_mux_arb.sv
// Scoreboard bench for rr_mux_arb (N=3, W=2): a behavioural model predicts grants and pushes
// expected words into a queue that is compared against y/y_chan as the DUT delivers them.
module tb_rr_mux_arb;
  localparam int N  = 3;
  localparam int W  = 2;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            mode;
  logic [SW-1:0]   s;
  logic [N*W-1:0]  a;
  logic [N-1:0]    a_valid;
  logic [N-1:0]    a_ready;
  logic [W-1:0]    y;
  logic [SW-1:0]   y_chan;
  logic            y_valid;
  logic            y_ready;
`ifdef RR_MUX_ERR_CNT_EN
  logic [7:0]      err_cnt;
  int              m_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  int                m_ptr;
  bit                m_valid;
  logic [SW+W-1:0]   sb[$];
  int                seen[$];
  int                rr_exp[10] = '{0, 1, 2, 0, 1, 2, 0, 2, 0, 2};

  always #5 clk = ~clk;

  rr_mux_arb #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .s       (s),
    .a       (a),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .y       (y),
    .y_chan  (y_chan),
    .y_valid (y_valid),
`ifdef RR_MUX_ERR_CNT_EN
    .y_ready (y_ready),
    .err_cnt (err_cnt)
`else
    .y_ready (y_ready)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    sb.delete();
    seen.delete();
    m_ptr   = N - 1;
    m_valid = 1'b0;
`ifdef RR_MUX_ERR_CNT_EN
    m_err = 0;
`endif
  endtask

  // Called at posedge+1 with inputs driven; samples at posedge+2, then advances one clock.
  task automatic cyc();
    bit              gv;
    int              g;
    int              c;
    logic [N-1:0]    exp_ready;
    logic [SW+W-1:0] head;
    #1;
    gv = 1'b0;
    g  = 0;
    if (mode == 1'b0) begin
      if (int'(s) < N && a_valid[s]) begin
        gv = 1'b1;
        g  = int'(s);
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        c = (m_ptr + k) % N;
        if (!gv && a_valid[c]) begin
          gv = 1'b1;
          g  = c;
        end
      end
    end
    exp_ready = '0;
    if (gv && (!m_valid || y_ready)) exp_ready[g] = 1'b1;
    check("a_ready", 32'(a_ready), 32'(exp_ready));
    check("y_valid", 32'(y_valid), 32'(m_valid));
    if (m_valid && sb.size() > 0) begin
      head = sb[0];
      check("y_chan", 32'(y_chan), 32'(head[SW+W-1:W]));
      check("y", 32'(y), 32'(head[W-1:0]));
      if (y_ready) begin
        void'(sb.pop_front());
        seen.push_back(int'(y_chan));
        $display("deliver chan=%0d y=%0h t=%0t", y_chan, y, $time);
      end
    end
`ifdef RR_MUX_ERR_CNT_EN
    check("err_cnt", 32'(err_cnt), 32'(m_err));
    if (!mode && int'(s) >= N && (|a_valid) && m_err < 255) m_err++;
`endif
    if (exp_ready != '0) begin
      sb.push_back({SW'(g), a[g*W +: W]});
      m_ptr   = g;
      m_valid = 1'b1;
    end else if (y_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mode = 1'b1; s = '0; a = '0; a_valid = 3'b111; y_ready = 1'b1;
    model_reset();
    #3;
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_y_chan", 32'(y_chan), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // fixed select
    mode = 1'b0; s = 2'd2; a = 6'b10_01_11; a_valid = 3'b111; y_ready = 1'b1;
    cyc();
    check("fix_y", 32'(y), 32'h2);
    check("fix_y_chan", 32'(y_chan), 32'd2);
    check("fix_y_valid", 32'(y_valid), 32'd1);
    a_valid = 3'b000;
    cyc();

    // out-of-range select
    s = 2'd0; a_valid = 3'b111;
    cyc();
    s = 2'd3;
    cyc();
    cyc();
    check("oor_y_valid", 32'(y_valid), 32'd0);
`ifdef RR_MUX_ERR_CNT_EN
    repeat (260) cyc();
    check("err_sat", 32'(err_cnt), 32'd255);
`endif

    // backpressure
    s = 2'd1; a = 6'b00_10_00; a_valid = 3'b010; y_ready = 1'b1;
    cyc();
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 6'($urandom); a_valid = 3'b111;
      cyc();
      check("bp_y", 32'(y), 32'h2);
      check("bp_y_chan", 32'(y_chan), 32'd1);
    end
    y_ready = 1'b1; s = 2'd0;
    cyc();
    check("bp_reload_valid", 32'(y_valid), 32'd1);

    // reset mid-operation with y = 2'b10 held
    s = 2'd1; a = 6'b00_10_00; a_valid = 3'b010; y_ready = 1'b1;
    cyc();
    y_ready = 1'b0;
    cyc();
    check("pre_rst_y", 32'(y), 32'h2);
    #4;
    mode = 1'b1; a_valid = 3'b111; y_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("mid_rst_y_valid", 32'(y_valid), 32'd0);
    check("mid_rst_y", 32'(y), 32'd0);
    check("mid_rst_y_chan", 32'(y_chan), 32'd0);
    check("mid_rst_a_ready", 32'(a_ready), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    // round-robin
    a = 6'b11_10_01; a_valid = 3'b111; y_ready = 1'b1;
    #1;
    check("rr_first_grant", 32'(a_ready), 32'b001);
    #(-0);
    repeat (6) cyc();
    a_valid = 3'b101;
    repeat (4) cyc();
    a_valid = 3'b000;
    cyc();
    check("rr_count", 32'(seen.size()), 32'd10);
    for (int i = 0; i < 10 && i < seen.size(); i++)
      check($sformatf("rr_seq%0d", i), 32'(seen[i]), 32'(rr_exp[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
